mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control unit for the MIPS core. It sequences a shared datapath (PC, IR, GPR file, one ALU, unified memory port) through FETCH/DECODE/EXECUTE/MEM/WB states for the supported subset. It supports memory wait states and counts retired instructions. It sits between the IR opcode/funct fields and every datapath enable and mux select.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `op`  in  6  IR[31:26]
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU result == 0
- `mem_ready`  in  1  memory completes the current access this cycle; tie to 1 for zero-wait memory
- `mem_req`  out  1  memory access active
- `mem_we`  out  1  store
- `ir_we`, `pc_we`  out  1  register load strobes
- `pc_src`  out  2  0 = PC+4, 1 = branch target, 2 = {PC[31:28],imm26,00}, 3 = GPR[rs]
- `alu_op`  out  2  0 = ADD, 1 = SUB, 2 = OR, 3 = LUI (imm<<16)
- `alu_srcb`  out  2  0 = GPR[rt], 1 = sign-extended imm16, 2 = zero-extended imm16
- `gpr_we`  out  1  GPR write strobe
- `gpr_dst`  out  2  0 = rt, 1 = rd, 2 = $31
- `gpr_wsel`  out  2  0 = ALU-out register, 1 = MDR, 2 = PC
- `instr_done`  out  1  one-cycle pulse on an instruction's last cycle
- `illegal`  out  1  one-cycle pulse, undecodable instruction
- `instr_cnt`  out  32  retired-instruction count
- `state_o`  out  4  current state, for debug

## Operation
- Moore outputs, decoded from the registered state only. `op` and `funct` are sampled only in DECODE, and the IR holds them stable.
- Unlisted outputs are 0 in every state.
- States and transitions:
  - RESET: all outputs 0 → FETCH.
  - FETCH: `mem_req`=1. When `mem_ready`=1: `ir_we`=`pc_we`=1, `pc_src`=0 → DECODE. Otherwise hold in FETCH with the strobes at 0.
  - DECODE:
    - addu (0/100001), subu (0/100011) → EXE_R
    - jr (0/001000) → JR
    - ori (001101), lui (001111) → EXE_I
    - lw (100011), sw (101011) → MEM_ADDR
    - beq (000100) → BRANCH
    - j (000010) → JUMP
    - jal (000011) → JAL
    - sll (0/000000) → FETCH with `instr_done`=1, treated as nop.
    - Anything else → FETCH with `instr_done`=`illegal`=1.
  - EXE_R: `alu_srcb`=0, `alu_op`=ADD for addu, SUB for subu → WB_ALU.
  - EXE_I: ori uses OR with `alu_srcb`=2; lui uses LUI → WB_ALU.
  - WB_ALU: `gpr_we`=1, `gpr_wsel`=0, `gpr_dst`=1 for R-type, 0 for I-type; `instr_done` → FETCH.
  - MEM_ADDR: ADD, `alu_srcb`=1 → MEM_RD for lw, MEM_WR for sw.
  - MEM_RD: `mem_req`=1; wait for `mem_ready` (MDR loads on that cycle) → WB_MEM.
  - WB_MEM: `gpr_we`=1, `gpr_wsel`=1, `gpr_dst`=0, `instr_done` → FETCH.
  - MEM_WR: `mem_req`=`mem_we`=1 held until `mem_ready`; `instr_done` on the `mem_ready` cycle → FETCH.
  - BRANCH: SUB with `alu_srcb`=0, `pc_src`=1, `pc_we`=`zero`, `instr_done` → FETCH.
  - JUMP: `pc_we`=1, `pc_src`=2, `instr_done` → FETCH.
  - JAL: as JUMP, plus `gpr_we`=1, `gpr_dst`=2, `gpr_wsel`=2. The GPR captures the pre-edge PC (= PC+4).
  - JR: `pc_we`=1, `pc_src`=3, `instr_done` → FETCH.
- `instr_cnt` increments on every `instr_done` cycle, including nop and illegal. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset: state=RESET, `instr_cnt`=0, all outputs 0 while `rst`=1. The first FETCH is one cycle after `rst` falls.
- `rst` asserted mid-instruction aborts immediately. No GPR or memory write is issued afterwards.
- CPI with zero-wait memory:
  - R-type / I-type: 4
  - lw: 5
  - sw: 4
  - beq, j, jal, jr: 3
  - nop/illegal: 2
- Each `mem_ready`=0 cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle. No strobe repeats.
- `mem_ready` is ignored outside FETCH, MEM_RD and MEM_WR.
- `pc_we` and `ir_we` are asserted for exactly one cycle per fetch. `gpr_we` is asserted for exactly one cycle per writing instruction.

## Structure
- Package `mc_pkg`: state encoding (4-bit), opcode/funct constants, `pc_src`/`alu_op`/`alu_srcb`/`gpr_dst`/`gpr_wsel` encodings.
- Sub-module `mc_decode`: combinational op/funct → instruction class (R_ALU, JR, I_ALU, LOAD, STORE, BRANCH, JUMP, JAL, NOP, ILLEGAL).
- `mc_ctrl`: state register, next-state logic, output decode, `instr_cnt`.

## Test plan
- Reset and zero-wait addu (op 0, funct 100001):
  - States RESET, FETCH, DECODE, EXE_R, WB_ALU.
  - WB_ALU has `gpr_we`=1 and `gpr_dst`=1.
  - `instr_done` in cycle 4 after FETCH entry; `instr_cnt`=1.
- lw with `mem_ready` low for 2 cycles in FETCH and 3 in MEM_RD:
  - CPI 10.
  - `ir_we` pulses exactly once.
  - Single `gpr_we` with `gpr_wsel`=1.
- beq taken vs. not taken:
  - `zero`=1 gives `pc_we`=1 with `pc_src`=1.
  - `zero`=0 gives `pc_we`=0.
  - Both complete in 3 cycles.
- jal:
  - JAL state shows `pc_src`=2, `gpr_dst`=2, `gpr_wsel`=2, `gpr_we`=1.
  - jr next gives `pc_src`=3.
- Opcode 111111:
  - DECODE pulses `illegal` and `instr_done`, then returns to FETCH.
  - sll 0 pulses `instr_done` only.
- `rst` asserted during MEM_WR with `mem_ready`=0:
  - `mem_we` drops immediately and `state_o`=RESET.
  - `instr_cnt`=0.
  - 0xFFFFFFFF preload check (forced): `instr_cnt` wraps to 0 after one instruction.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// datapath mux selects and the decoded-instruction payload.
package mc_pkg;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXE_R    = 4'd3,
    S_EXE_I    = 4'd4,
    S_WB_ALU   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13
  } state_t;

  typedef enum logic [3:0] {
    C_R_ALU, C_JR, C_I_ALU, C_LOAD, C_STORE,
    C_BRANCH, C_JUMP, C_JAL, C_NOP, C_ILLEGAL
  } iclass_t;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  localparam logic [SEL_W-1:0] PC_SEQ = 2'd0, PC_BR = 2'd1, PC_JMP = 2'd2, PC_REG = 2'd3;
  localparam logic [SEL_W-1:0] ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_OR = 2'd2, ALU_LUI = 2'd3;
  localparam logic [SEL_W-1:0] SRCB_RT = 2'd0, SRCB_SEXT = 2'd1, SRCB_ZEXT = 2'd2;
  localparam logic [SEL_W-1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
  localparam logic [SEL_W-1:0] WSEL_ALU = 2'd0, WSEL_MDR = 2'd1, WSEL_PC = 2'd2;

  typedef struct packed {
    iclass_t          cls;
    logic [SEL_W-1:0] alu_op;
  } dec_t;

endpackage

// File: rtl/mc_if.sv
// Control bundle between the control unit (master) and the shared datapath (slave).
interface mc_if;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic [1:0]  alu_op;
  logic [1:0]  alu_srcb;
  logic        gpr_we;
  logic [1:0]  gpr_dst;
  logic [1:0]  gpr_wsel;
  logic        instr_done;
  logic        illegal;
  logic [31:0] instr_cnt;
  logic [3:0]  state_o;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, mem_we, ir_we, pc_we, pc_src, alu_op, alu_srcb,
           gpr_we, gpr_dst, gpr_wsel, instr_done, illegal, instr_cnt, state_o
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, mem_we, ir_we, pc_we, pc_src, alu_op, alu_srcb,
           gpr_we, gpr_dst, gpr_wsel, instr_done, illegal, instr_cnt, state_o
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational IR opcode/funct decode into an instruction class plus the
// ALU operation that class needs in its execute step.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec.cls    = C_ILLEGAL;
    dec.alu_op = ALU_ADD;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_ADDU: dec.cls = C_R_ALU;
          FN_SUBU: begin dec.cls = C_R_ALU; dec.alu_op = ALU_SUB; end
          FN_JR:   dec.cls = C_JR;
          // any shift amount is accepted: sll is a nop here
          FN_SLL:  dec.cls = C_NOP;
          default: dec.cls = C_ILLEGAL;
        endcase
      end
      OP_ORI:  begin dec.cls = C_I_ALU; dec.alu_op = ALU_OR;  end
      OP_LUI:  begin dec.cls = C_I_ALU; dec.alu_op = ALU_LUI; end
      OP_LW:   dec.cls = C_LOAD;
      OP_SW:   dec.cls = C_STORE;
      OP_BEQ:  begin dec.cls = C_BRANCH; dec.alu_op = ALU_SUB; end
      OP_J:    dec.cls = C_JUMP;
      OP_JAL:  dec.cls = C_JAL;
      default: dec.cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences the shared datapath through
// fetch/decode/execute/memory/writeback and counts retired instructions.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  mc_if.master bus
);

  state_t           state_q;
  dec_t             dec;
  dec_t             dec_q;
  logic [CNT_W-1:0] cnt_q;

  mc_decode u_decode (
    .op    (bus.op),
    .funct (bus.funct),
    .dec   (dec)
  );

  // State sequencing; the decode result is captured once in DECODE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
      dec_q   <= '{cls: C_NOP, alu_op: ALU_ADD};
      cnt_q   <= '0;
    end else begin
      if (bus.instr_done) cnt_q <= cnt_q + CNT_W'(1);
      case (state_q)
        S_RESET:  state_q <= S_FETCH;
        S_FETCH:  if (bus.mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          dec_q <= dec;
          case (dec.cls)
            C_R_ALU:          state_q <= S_EXE_R;
            C_I_ALU:          state_q <= S_EXE_I;
            C_LOAD, C_STORE:  state_q <= S_MEM_ADDR;
            C_BRANCH:         state_q <= S_BRANCH;
            C_JUMP:           state_q <= S_JUMP;
            C_JAL:            state_q <= S_JAL;
            C_JR:             state_q <= S_JR;
            default:          state_q <= S_FETCH;
          endcase
        end
        S_EXE_R, S_EXE_I: state_q <= S_WB_ALU;
        S_MEM_ADDR: state_q <= (dec_q.cls == C_STORE) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (bus.mem_ready) state_q <= S_WB_MEM;
        S_MEM_WR:   if (bus.mem_ready) state_q <= S_FETCH;
        S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_JAL, S_JR: state_q <= S_FETCH;
        default:    state_q <= S_RESET;
      endcase
    end
  end

  // Datapath controls from the current state; only the memory-handshake
  // strobes, branch pc_we and DECODE completion look at live inputs
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.ir_we      = 1'b0;
    bus.pc_we      = 1'b0;
    bus.pc_src     = PC_SEQ;
    bus.alu_op     = ALU_ADD;
    bus.alu_srcb   = SRCB_RT;
    bus.gpr_we     = 1'b0;
    bus.gpr_dst    = DST_RT;
    bus.gpr_wsel   = WSEL_ALU;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_we = 1'b1;
          bus.pc_we = 1'b1;
        end
      end
      S_DECODE: begin
        bus.instr_done = (dec.cls == C_NOP) || (dec.cls == C_ILLEGAL);
        bus.illegal    = (dec.cls == C_ILLEGAL);
      end
      S_EXE_R: bus.alu_op = dec_q.alu_op;
      S_EXE_I: begin
        bus.alu_op   = dec_q.alu_op;
        bus.alu_srcb = (dec_q.alu_op == ALU_OR) ? SRCB_ZEXT : SRCB_RT;
      end
      S_WB_ALU: begin
        bus.gpr_we     = 1'b1;
        bus.gpr_dst    = (dec_q.cls == C_R_ALU) ? DST_RD : DST_RT;
        bus.instr_done = 1'b1;
      end
      S_MEM_ADDR: bus.alu_srcb = SRCB_SEXT;
      S_MEM_RD:   bus.mem_req = 1'b1;
      S_WB_MEM: begin
        bus.gpr_we     = 1'b1;
        bus.gpr_wsel   = WSEL_MDR;
        bus.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_req    = 1'b1;
        bus.mem_we     = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      S_BRANCH: begin
        bus.alu_op     = ALU_SUB;
        bus.pc_src     = PC_BR;
        bus.pc_we      = bus.zero;
        bus.instr_done = 1'b1;
      end
      S_JUMP: begin
        bus.pc_we      = 1'b1;
        bus.pc_src     = PC_JMP;
        bus.instr_done = 1'b1;
      end
      S_JAL: begin
        bus.pc_we      = 1'b1;
        bus.pc_src     = PC_JMP;
        bus.gpr_we     = 1'b1;
        bus.gpr_dst    = DST_RA;
        bus.gpr_wsel   = WSEL_PC;
        bus.instr_done = 1'b1;
      end
      S_JR: begin
        bus.pc_we      = 1'b1;
        bus.pc_src     = PC_REG;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.instr_cnt = cnt_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class through the FSM
// with scripted memory wait states and checks cycle counts and strobes.
module tb_mc_ctrl;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errs   = 0;

  mc_if bus ();

  mc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // results of the most recent run_instr call
  int         r_cyc, r_ir, r_pc, r_gpr, r_memwe, r_ill;
  logic [1:0] r_pcsrc, r_dst, r_wsel, r_alu, r_srcb;
  logic [15:0] r_seq;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction from a FETCH cycle to its retiring cycle, then
  // steps into the following cycle; memory is held off fw cycles in FETCH
  // and mw cycles in MEM_RD/MEM_WR; mem_ready is 0 in every other state.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int fw, input int mw);
    int   nf = 0;
    int   nm = 0;
    logic fin = 1'b0;
    r_cyc = 0; r_ir = 0; r_pc = 0; r_gpr = 0; r_memwe = 0; r_ill = 0;
    r_pcsrc = 2'd0; r_dst = 2'd0; r_wsel = 2'd0; r_alu = 2'd0; r_srcb = 2'd0;
    r_seq = 16'h0;
    bus.op = o; bus.funct = f; bus.zero = z;
    while (!fin && r_cyc < 60) begin
      if (bus.state_o == S_FETCH) begin
        bus.mem_ready = (nf >= fw); nf++;
      end else if (bus.state_o == S_MEM_RD || bus.state_o == S_MEM_WR) begin
        bus.mem_ready = (nm >= mw); nm++;
      end else begin
        bus.mem_ready = 1'b0;
      end
      #1;
      if (r_cyc < 4) r_seq = {r_seq[11:0], bus.state_o};
      if (bus.ir_we) r_ir++;
      if (bus.pc_we) r_pc++;
      if (bus.pc_we && bus.state_o != S_FETCH) r_pcsrc = bus.pc_src;
      if (bus.gpr_we) begin r_gpr++; r_dst = bus.gpr_dst; r_wsel = bus.gpr_wsel; end
      if (bus.mem_we) r_memwe++;
      if (bus.illegal) r_ill++;
      if (bus.state_o == S_EXE_R || bus.state_o == S_EXE_I ||
          bus.state_o == S_MEM_ADDR || bus.state_o == S_BRANCH) begin
        r_alu = bus.alu_op; r_srcb = bus.alu_srcb;
      end
      r_cyc++;
      if (bus.instr_done) fin = 1'b1;
      else nxt();
    end
    if (fin) nxt();
  endtask

  task automatic test_reset();
    bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    rst = 1'b1;
    nxt(); nxt();
    checks++;
    if (bus.state_o !== 4'd0) begin errs++; $display("FAIL reset_state: got %0d want 0", bus.state_o); end
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.ir_we, bus.pc_we, bus.gpr_we, bus.instr_done, bus.illegal,
         bus.pc_src, bus.alu_op, bus.alu_srcb, bus.gpr_dst, bus.gpr_wsel} !== 17'd0) begin
      errs++; $display("FAIL reset_outputs: some output nonzero during reset");
    end
    checks++;
    if (bus.instr_cnt !== 32'd0) begin errs++; $display("FAIL reset_cnt: got %0h want 0", bus.instr_cnt); end
    rst = 1'b0;
    nxt();
    checks++;
    if (bus.state_o !== 4'd1) begin errs++; $display("FAIL reset_first_fetch: got %0d want 1", bus.state_o); end
  endtask

  task automatic test_alu();
    run_instr(6'b000000, 6'b100001, 1'b0, 0, 0);
    checks++;
    if (r_seq !== 16'h1235) begin errs++; $display("FAIL addu_states: got %h want 1235", r_seq); end
    checks++;
    if (r_cyc !== 4) begin errs++; $display("FAIL addu_cpi: got %0d want 4", r_cyc); end
    checks++;
    if (r_gpr !== 1 || r_dst !== 2'd1 || r_wsel !== 2'd0) begin
      errs++; $display("FAIL addu_wb: gpr_we %0d dst %0d wsel %0d want 1 1 0", r_gpr, r_dst, r_wsel);
    end
    checks++;
    if (r_alu !== 2'd0 || r_ir !== 1) begin errs++; $display("FAIL addu_alu: alu %0d ir %0d want 0 1", r_alu, r_ir); end
    checks++;
    if (bus.instr_cnt !== 32'd1) begin errs++; $display("FAIL addu_cnt: got %0d want 1", bus.instr_cnt); end

    run_instr(6'b000000, 6'b100011, 1'b0, 0, 0);
    checks++;
    if (r_cyc !== 4 || r_alu !== 2'd1) begin errs++; $display("FAIL subu: cpi %0d alu %0d want 4 1", r_cyc, r_alu); end

    run_instr(6'b001101, 6'b111111, 1'b0, 0, 0);
    checks++;
    if (r_seq !== 16'h1245 || r_cyc !== 4) begin errs++; $display("FAIL ori_seq: seq %h cpi %0d want 1245 4", r_seq, r_cyc); end
    checks++;
    if (r_alu !== 2'd2 || r_srcb !== 2'd2 || r_dst !== 2'd0) begin
      errs++; $display("FAIL ori_ctl: alu %0d srcb %0d dst %0d want 2 2 0", r_alu, r_srcb, r_dst);
    end
    checks++;
    if (bus.instr_cnt !== 32'd3) begin errs++; $display("FAIL ori_cnt: got %0d want 3", bus.instr_cnt); end
  endtask

  task automatic test_mem_waits();
    run_instr(6'b100011, 6'b000000, 1'b0, 2, 3);
    checks++;
    if (r_cyc !== 10) begin errs++; $display("FAIL lw_cpi: got %0d want 10", r_cyc); end
    checks++;
    if (r_seq !== 16'h1112) begin errs++; $display("FAIL lw_states: got %h want 1112", r_seq); end
    checks++;
    if (r_ir !== 1 || r_pc !== 1) begin errs++; $display("FAIL lw_fetch_strobes: ir %0d pc %0d want 1 1", r_ir, r_pc); end
    checks++;
    if (r_gpr !== 1 || r_wsel !== 2'd1 || r_dst !== 2'd0) begin
      errs++; $display("FAIL lw_wb: gpr_we %0d wsel %0d dst %0d want 1 1 0", r_gpr, r_wsel, r_dst);
    end
    checks++;
    if (r_srcb !== 2'd1 || r_alu !== 2'd0) begin errs++; $display("FAIL lw_addr: srcb %0d alu %0d want 1 0", r_srcb, r_alu); end

    run_instr(6'b101011, 6'b000000, 1'b0, 0, 0);
    checks++;
    if (r_cyc !== 4 || r_memwe !== 1 || r_gpr !== 0) begin
      errs++; $display("FAIL sw_nowait: cpi %0d mem_we %0d gpr_we %0d want 4 1 0", r_cyc, r_memwe, r_gpr);
    end
    run_instr(6'b101011, 6'b000000, 1'b0, 0, 2);
    checks++;
    if (r_cyc !== 6 || r_memwe !== 3) begin errs++; $display("FAIL sw_wait: cpi %0d mem_we %0d want 6 3", r_cyc, r_memwe); end
    checks++;
    if (bus.instr_cnt !== 32'd6) begin errs++; $display("FAIL mem_cnt: got %0d want 6", bus.instr_cnt); end
  endtask

  task automatic test_branch();
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
    checks++;
    if (r_cyc !== 3 || r_pc !== 2 || r_pcsrc !== 2'd1) begin
      errs++; $display("FAIL beq_taken: cpi %0d pc_we %0d pc_src %0d want 3 2 1", r_cyc, r_pc, r_pcsrc);
    end
    checks++;
    if (r_alu !== 2'd1 || r_srcb !== 2'd0) begin errs++; $display("FAIL beq_alu: alu %0d srcb %0d want 1 0", r_alu, r_srcb); end
    run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
    checks++;
    if (r_cyc !== 3 || r_pc !== 1) begin errs++; $display("FAIL beq_not_taken: cpi %0d pc_we %0d want 3 1", r_cyc, r_pc); end
  endtask

  task automatic test_jumps();
    run_instr(6'b000011, 6'b000000, 1'b0, 0, 0);
    checks++;
    if (r_cyc !== 3 || r_pcsrc !== 2'd2) begin errs++; $display("FAIL jal_pc: cpi %0d pc_src %0d want 3 2", r_cyc, r_pcsrc); end
    checks++;
    if (r_gpr !== 1 || r_dst !== 2'd2 || r_wsel !== 2'd2) begin
      errs++; $display("FAIL jal_link: gpr_we %0d dst %0d wsel %0d want 1 2 2", r_gpr, r_dst, r_wsel);
    end
    run_instr(6'b000000, 6'b001000, 1'b0, 0, 0);
    checks++;
    if (r_cyc !== 3 || r_pcsrc !== 2'd3 || r_gpr !== 0) begin
      errs++; $display("FAIL jr: cpi %0d pc_src %0d gpr_we %0d want 3 3 0", r_cyc, r_pcsrc, r_gpr);
    end
    run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);
    checks++;
    if (r_cyc !== 3 || r_pcsrc !== 2'd2 || r_gpr !== 0) begin
      errs++; $display("FAIL j: cpi %0d pc_src %0d gpr_we %0d want 3 2 0", r_cyc, r_pcsrc, r_gpr);
    end
  endtask

  task automatic test_illegal_nop();
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
    checks++;
    if (r_cyc !== 2 || r_ill !== 1) begin errs++; $display("FAIL illegal: cpi %0d illegal %0d want 2 1", r_cyc, r_ill); end
    checks++;
    if (bus.state_o !== 4'd1) begin errs++; $display("FAIL illegal_return: state %0d want 1", bus.state_o); end
    run_instr(6'b000000, 6'b000000, 1'b0, 0, 0);
    checks++;
    if (r_cyc !== 2 || r_ill !== 0 || r_gpr !== 0) begin
      errs++; $display("FAIL nop: cpi %0d illegal %0d gpr_we %0d want 2 0 0", r_cyc, r_ill, r_gpr);
    end
    checks++;
    if (bus.instr_cnt !== 32'd13) begin errs++; $display("FAIL total_cnt: got %0d want 13", bus.instr_cnt); end
  endtask

  task automatic test_reset_mid_store();
    bus.op = 6'b101011; bus.funct = 6'd0; bus.mem_ready = 1'b1;
    #1;
    nxt();
    bus.mem_ready = 1'b0;
    nxt(); nxt();
    #1;
    checks++;
    if (bus.state_o !== 4'd9 || bus.mem_we !== 1'b1) begin
      errs++; $display("FAIL pre_abort: state %0d mem_we %0b want 9 1", bus.state_o, bus.mem_we);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_req !== 1'b0 || bus.state_o !== 4'd0) begin
      errs++; $display("FAIL abort: mem_we %0b mem_req %0b state %0d want 0 0 0", bus.mem_we, bus.mem_req, bus.state_o);
    end
    checks++;
    if (bus.instr_cnt !== 32'd0) begin errs++; $display("FAIL abort_cnt: got %0d want 0", bus.instr_cnt); end
    bus.mem_ready = 1'b1;
    nxt();
    checks++;
    if (bus.mem_we !== 1'b0 || bus.gpr_we !== 1'b0 || bus.instr_done !== 1'b0) begin
      errs++; $display("FAIL abort_hold: mem_we %0b gpr_we %0b done %0b want 0 0 0", bus.mem_we, bus.gpr_we, bus.instr_done);
    end
    rst = 1'b0;
    nxt();
  endtask

  task automatic test_wrap();
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    #1;
    checks++;
    if (bus.instr_cnt !== 32'hFFFF_FFFF) begin errs++; $display("FAIL preload: got %h want ffffffff", bus.instr_cnt); end
    run_instr(6'b000000, 6'b000000, 1'b0, 0, 0);
    checks++;
    if (bus.instr_cnt !== 32'd0) begin errs++; $display("FAIL wrap: got %h want 0", bus.instr_cnt); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem_waits();
    test_branch();
    test_jumps();
    test_illegal_nop();
    test_reset_mid_store();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
